// File: rtl/seq_alu.sv
// seq_alu: registered WIDTH-bit ALU behind a valid/ready handshake, with a shift-add multiplier
// Ports: clk, rst_n (async, active-low); x, y operands and s opcode, captured on in_valid && in_ready;
//        z result with flag_c/flag_z/flag_v, presented while out_valid and consumed on out_ready.
// Vectors use [0:WIDTH-1] indexing, so bit 0 is the MSB.
// Macro SEQ_ALU_FLAGS_EN compiles in the status flags; without it they are tied to 0.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [0:WIDTH-1] x,
   input  logic [0:WIDTH-1] y,
   input  logic [0:2]       s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [0:WIDTH-1] z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_v
);
   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(H) + 1;
`ifdef SEQ_ALU_FLAGS_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a;
   logic [H-1:0]     b;
   logic [CW-1:0]    cnt;
   logic             accept, last;
   logic [SW-1:0]    sum, diff;
   logic [WIDTH-1:0] res, acc_nx;

   assign sum    = SW'(x) + SW'(y);
   assign diff   = SW'(x) - SW'(y);
   assign last   = cnt == CW'(H - 1);
   // z doubles as the product accumulator while the multiply iterates
   assign acc_nx = z + (b[0] ? a : '0);
   assign res    = s == 3'd0 ? ~x :
                   s == 3'd1 ? x | y :
                   s == 3'd2 ? x & y :
                   s == 3'd3 ? x ^ y :
                   s == 3'd4 ? sum[WIDTH-1:0] :
                   s == 3'd5 ? diff[WIDTH-1:0] :
                   {{(WIDTH - 3){1'b0}}, x > y, x == y, x < y};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      in_ready  = state == IDLE || (state == HOLD && out_ready);
      out_valid = state == HOLD;
      accept    = in_valid && in_ready;
      state_nx  = state == MUL ? (last ? HOLD : MUL) :
                  accept ? (s == 3'd7 ? MUL : HOLD) :
                  (state == HOLD && !out_ready) ? HOLD : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         z   <= '0;
         a   <= '0;
         b   <= '0;
         cnt <= '0;
      end else if (accept && s == 3'd7) begin
         z   <= '0;
         a   <= {{(WIDTH - H){1'b0}}, x[H:WIDTH-1]};
         b   <= y[H:WIDTH-1];
         cnt <= '0;
      end else if (accept) begin
         z <= res;
      end else if (state == MUL) begin
         z   <= acc_nx;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + 1'b1;
      end

`ifdef SEQ_ALU_FLAGS_EN
   logic c_nx, v_nx;

   // x[0], y[0] and bit WIDTH-1 of sum/diff are the sign bits
   assign c_nx = s == 3'd4 ? sum[WIDTH] : s == 3'd5 ? diff[WIDTH] : 1'b0;
   assign v_nx = s == 3'd4 ? (x[0] == y[0] && sum[WIDTH-1] != x[0]) :
                 s == 3'd5 ? (x[0] != y[0] && diff[WIDTH-1] != x[0]) : 1'b0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_v <= 1'b0;
      end else if (accept && s != 3'd7) begin
         flag_c <= c_nx;
         flag_z <= res == '0;
         flag_v <= v_nx;
      end else if (state == MUL && last) begin
         flag_c <= 1'b0;
         flag_z <= acc_nx == '0;
         flag_v <= 1'b0;
      end
`else
   assign flag_c = 1'b0;
   assign flag_z = 1'b0;
   assign flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8 and WIDTH=16
module tb_seq_alu;
`ifdef SEQ_ALU_FLAGS_EN
   localparam logic FE = 1'b1;
`else
   localparam logic FE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:7]  x, y, z;
   logic [0:2]  s;
   logic        in_valid, in_ready, out_valid, out_ready, fc, fz, fv;
   logic [0:15] x16, y16, z16;
   logic [0:2]  s16;
   logic        iv16, ir16, ov16, or16, fc16, fz16, fv16;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .s(s), .in_valid(in_valid), .in_ready(in_ready),
      .z(z), .out_valid(out_valid), .out_ready(out_ready),
      .flag_c(fc), .flag_z(fz), .flag_v(fv)
   );

   seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .x(x16), .y(y16), .s(s16), .in_valid(iv16), .in_ready(ir16),
      .z(z16), .out_valid(ov16), .out_ready(or16),
      .flag_c(fc16), .flag_z(fz16), .flag_v(fv16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic c, input logic zf, input logic v);
      chk({tag, "_c"}, fc, c);
      chk({tag, "_z"}, fz, zf);
      chk({tag, "_v"}, fv, v);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; s = '0;
      x16 = '0; y16 = '0; s16 = '0; iv16 = 1'b0; or16 = 1'b0;
      #3;
      chk("rst_z", z, 0);
      chk("rst_ov", out_valid, 0);
      chk_flags("rst", 1'b0, 1'b0, 1'b0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rst_ir", in_ready, 1);

      // add with overflow
      x = 8'h7F; y = 8'h01; s = 3'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("add_ov", out_valid, 1);
      chk("add_z", z, 8'h80);
      chk_flags("add", 1'b0, 1'b0, FE);
      out_ready = 1'b1;
      step();
      chk("add_done", out_valid, 0);

      // sub with borrow, then equal operands chained with no bubble
      out_ready = 1'b0;
      x = 8'h05; y = 8'h06; s = 3'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("sub_z", z, 8'hFF);
      chk_flags("sub", FE, 1'b0, 1'b0);
      #1;
      chk("sub_ir_hold", in_ready, 0);
      out_ready = 1'b1; x = 8'h33; y = 8'h33; in_valid = 1'b1;
      #1;
      chk("sub_ir_take", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("sub0_ov", out_valid, 1);
      chk("sub0_z", z, 8'h00);
      chk_flags("sub0", 1'b0, FE, 1'b0);
      step();
      chk("sub0_done", out_valid, 0);

      // multiply, with operands changed and in_valid held during iterations
      x = 8'hAF; y = 8'h3D; s = 3'd7; in_valid = 1'b1;
      step();
      x = 8'h00; y = 8'hFF; s = 3'd0;
      for (int i = 1; i <= 3; i++) begin
         chk("mul_ir", in_ready, 0);
         chk("mul_ov", out_valid, 0);
         step();
      end
      chk("mul_ir3", in_ready, 0);
      chk("mul_ov3", out_valid, 0);
      step();
      in_valid = 1'b0;
      chk("mul_ov4", out_valid, 1);
      chk("mul_z", z, 8'hC3);
      chk_flags("mul", 1'b0, 1'b0, 1'b0);
      step();
      chk("mul_done", out_valid, 0);

      // back-pressure on an XOR result
      out_ready = 1'b0;
      x = 8'hF0; y = 8'h3C; s = 3'd3; in_valid = 1'b1;
      step();
      x = 8'h01; y = 8'h02; s = 3'd1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_z", z, 8'hCC);
         chk("bp_ov", out_valid, 1);
         chk("bp_ir", in_ready, 0);
         step();
      end
      chk("bp_z_end", z, 8'hCC);
      // streaming ORs, one result per edge
      out_ready = 1'b1;
      step();
      chk("or1_ov", out_valid, 1);
      chk("or1_z", z, 8'h03);
      x = 8'h10; y = 8'h20;
      step();
      chk("or2_ov", out_valid, 1);
      chk("or2_z", z, 8'h30);
      x = 8'h40; y = 8'h04;
      step();
      chk("or3_ov", out_valid, 1);
      chk("or3_z", z, 8'h44);

      // compare: less, greater, equal
      x = 8'h10; y = 8'h20; s = 3'd6;
      step();
      chk("cmp_lt", z, 8'h01);
      x = 8'h20; y = 8'h10;
      step();
      chk("cmp_gt", z, 8'h04);
      x = 8'h5A; y = 8'h5A;
      step();
      chk("cmp_eq", z, 8'h02);
      chk_flags("cmp", 1'b0, 1'b0, 1'b0);
      // NOT
      x = 8'h5A; s = 3'd0;
      step();
      chk("not_z", z, 8'hA5);
      // AND
      x = 8'hF0; y = 8'h3C; s = 3'd2;
      step();
      chk("and_z", z, 8'h30);

      // reset during the second multiply iteration
      x = 8'h0F; y = 8'h0F; s = 3'd7;
      step();
      in_valid = 1'b0;
      step();
      chk("mrst_ov_pre", out_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("mrst_z", z, 0);
      chk("mrst_ov", out_valid, 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("mrst_ir", in_ready, 1);
      step();
      chk("mrst_idle_ov", out_valid, 0);
      chk("mrst_idle_z", z, 0);

      // WIDTH=16 multiply: 0xFF * 0xFF over 8 iterations
      x16 = 16'h00FF; y16 = 16'h00FF; s16 = 3'd7; iv16 = 1'b1;
      step();
      iv16 = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         chk("m16_ov", ov16, 0);
         step();
      end
      chk("m16_ov7", ov16, 0);
      step();
      chk("m16_ov8", ov16, 1);
      chk("m16_z", z16, 16'hFE01);
      chk("m16_c", fc16, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor of the team's 8-bit combinational ALU. Performs the same eight operations on WIDTH-bit operands behind a valid/ready handshake, with a multi-cycle shift-add multiplier and optional status flags. Sits between an operand-issuing controller and a result consumer in the datapath, and replaces the combinational ALU wherever back-pressure or a clocked result is needed.

## Interface
- WIDTH, 8: operand and result width. Must be even and ≥ 4.
- CLK input 1: single clock, rising-edge.
- RST_N input 1: asynchronous active-low reset.
- X input [0:WIDTH-1]: operand A; bit 0 is the MSB.
- Y input [0:WIDTH-1]: operand B; bit 0 is the MSB.
- S input [0:2]: opcode.
- IN_VALID input 1: X, Y and S are valid.
- IN_READY output 1: block accepts an operation this cycle.
- Z output [0:WIDTH-1]: result; bit 0 is the MSB.
- OUT_VALID output 1: Z and the flags are valid.
- OUT_READY input 1: the consumer takes the result this cycle.
- FLAG_C output 1: carry/borrow.
- FLAG_Z output 1: Z == 0.
- FLAG_V output 1: two's-complement overflow.

## Operation
- Opcodes:
  - 0: NOT X.
  - 1: X OR Y.
  - 2: X AND Y.
  - 3: X XOR Y.
  - 4: X+Y mod 2^WIDTH.
  - 5: X−Y mod 2^WIDTH.
  - 6: compare.
  - 7: multiply.
- Compare, unsigned: Z[WIDTH-3] = X>Y, Z[WIDTH-2] = X==Y, Z[WIDTH-1] = X<Y. All other bits are 0.
- Multiply: the low WIDTH/2 bits of X times the low WIDTH/2 bits of Y, unsigned. The full WIDTH-bit product is exact, with no truncation.
- Operands and opcode are captured on acceptance. Later changes to X, Y or S do not affect an operation in flight.
- FSM states:
  - IDLE: no operation in flight.
  - MUL: multiply iterating.
  - HOLD: result held until the consumer takes it.
- FSM transitions:
  - IDLE to HOLD on acceptance of opcodes 0–6.
  - IDLE to MUL on acceptance of opcode 7.
  - MUL to HOLD after the last iteration.
  - HOLD to IDLE when OUT_READY=1, or to HOLD/MUL directly if a new operation is accepted in the same cycle.
- Acceptance occurs when IN_VALID && IN_READY at a rising edge.
- IN_READY = (state==IDLE) || (state==HOLD && OUT_READY).
- MUL: the multiplier shifts one bit per cycle and adds the partial product when the current multiplier bit is 1. It runs for WIDTH/2 iterations.
- OUT_VALID = (state==HOLD). Z and the flags are stable while OUT_VALID=1 and OUT_READY=0.
- Flags (when compiled in):
  - Add: C = carry out of the MSB. V = both operands have equal sign and the result sign differs.
  - Sub: C = borrow (X<Y unsigned). V = operands have different signs and the result sign differs from X.
  - Z flag: set for every opcode.
  - C and V: 0 for opcodes 0–3, 6 and 7.
- Illegal opcodes do not exist; all eight codes are defined.

## Timing
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - Z=0, OUT_VALID=0, FLAG_C=0, FLAG_Z=0, FLAG_V=0.
  - IN_READY=1 once RST_N is released and the block is in IDLE.
- Opcodes 0–6: accepted at edge k, so OUT_VALID=1 after edge k. Latency is 1 cycle.
- Opcode 7: accepted at edge k, then iterates at edges k+1 … k+WIDTH/2. OUT_VALID=1 after edge k+WIDTH/2, which is 4 cycles for WIDTH=8.
- Back-to-back: result consumed and new operation accepted at the same edge gives no bubble. Peak throughput for opcodes 0–6 is 1 operation per cycle.
- During MUL: IN_READY=0 and OUT_VALID=0. IN_VALID is ignored.
- Reset asserted mid-MUL or mid-HOLD: the operation is abandoned and the result is lost. The first cycle after release is IDLE.
- Unconsumed result: held indefinitely. No new operation is accepted until OUT_READY=1.

## Configuration
- Macro SEQ_ALU_FLAGS_EN.
- Defined: FLAG_C, FLAG_Z and FLAG_V are registered with Z and behave as specified above.
- Undefined: flag logic is removed. FLAG_C, FLAG_Z and FLAG_V are tied to 0. All other behaviour and timing are unchanged.

## Test plan
- Add with flags, WIDTH=8, macro on: X=0x7F, Y=0x01, S=4 → after 1 cycle Z=0x80, C=0, V=1, FLAG_Z=0.
- Sub with borrow: X=0x05, Y=0x06, S=5 → Z=0xFF, C=1, V=0. Then X=0x33, Y=0x33 → Z=0x00, FLAG_Z=1.
- Multiply: X=0xAF, Y=0x3D, S=7 (low nibbles 0xF×0xD) → Z=0xC3 exactly 4 cycles after acceptance. IN_READY=0 during iterations. X changed mid-operation has no effect.
- Back-pressure and streaming: hold OUT_READY=0 for 5 cycles after an XOR of 0xF0^0x3C. Z=0xCC stays stable and IN_READY=HOLD&&OUT_READY=0. Then stream 3 OR operations with OUT_READY=1: one result per cycle, no bubble.
- Compare, then reset: X=0x10, Y=0x20, S=6 → Z=0x01. Start a multiply, assert RST_N=0 at its second iteration → Z=0, OUT_VALID=0 immediately. IN_READY=1 after release.
- Macro off: repeat the first scenario → Z=0x80, all flags 0. WIDTH=16: X=0x00FF, Y=0x00FF, S=7 → Z=0xFE01 after 8 cycles.
